// File: rtl/instr_assembler_if.sv
// Command stream carrying instruction fields from the program-load source
// into the instruction assembler.
interface instr_assembler_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [63:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_assembler.sv
// Packs R/I/S/B instruction-field commands into 32-bit RV64 words and writes
// them sequentially into instruction memory, rejecting unencodable commands.
module instr_assembler #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  instr_assembler_if.slave    cmd,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [31:0]         imem_wdata,
  output logic [ADDR_W:0]     count,
  output logic                done,
  output logic                err,
  output logic [2:0]          err_code,
  output logic [ADDR_W-1:0]   err_addr
);

  localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W+1)'((1 << ADDR_W) - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [6:0]        OP_STORE  = 7'b0100011;
  localparam logic [6:0]        OP_BRANCH = 7'b1100011;

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_S = 2'd2;
  localparam logic [1:0] FMT_B = 2'd3;

  localparam logic [2:0] EC_NONE  = 3'd0;
  localparam logic [2:0] EC_RANGE = 3'd1;
  localparam logic [2:0] EC_ALIGN = 3'd2;
  localparam logic [2:0] EC_FMT   = 3'd3;
  localparam logic [2:0] EC_FULL  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t             state_r;
  logic [ADDR_W:0]    count_r;
  logic               we_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [31:0]        wdata_r;
  logic               done_r;
  logic               err_r;
  logic [2:0]         err_code_r;
  logic [ADDR_W-1:0]  err_addr_r;

  logic               accept_s;
  logic               full_s;
  logic [2:0]         code_s;
  logic [31:0]        word_s;
  logic [ADDR_W-1:0]  wr_addr_s;

  // Bit placement of each format; B drops imm[0], which must already be zero.
  function automatic logic [31:0] encode_word(
    input logic [1:0]  fmt,
    input logic [6:0]  opcode,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [63:0] imm
  );
    logic [31:0] w;
    case (fmt)
      FMT_R:   w = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   w = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // Error classification in priority order: full, format/opcode, range, alignment.
  function automatic logic [2:0] check_cmd(
    input logic        full,
    input logic [1:0]  fmt,
    input logic [6:0]  opcode,
    input logic [63:0] imm
  );
    logic       mismatch;
    logic       fits12;
    logic       fits13;
    logic [2:0] code;
    case (fmt)
      FMT_S:   mismatch = (opcode != OP_STORE);
      FMT_B:   mismatch = (opcode != OP_BRANCH);
      default: mismatch = (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endcase
    fits12 = (&imm[63:11]) || !(|imm[63:11]);
    fits13 = (&imm[63:12]) || !(|imm[63:12]);
    if (full) begin
      code = EC_FULL;
    end else if (mismatch) begin
      code = EC_FMT;
    end else begin
      case (fmt)
        FMT_I, FMT_S: code = fits12 ? EC_NONE : EC_RANGE;
        FMT_B:        code = !fits13 ? EC_RANGE : (imm[0] ? EC_ALIGN : EC_NONE);
        default:      code = EC_NONE;
      endcase
    end
    return code;
  endfunction

  assign cmd.in_ready = (state_r == S_LOAD);
  assign accept_s     = cmd.in_valid && (state_r == S_LOAD);
  assign full_s       = (count_r == DEPTH);
  assign wr_addr_s    = BASE + count_r[ADDR_W-1:0];
  assign code_s       = check_cmd(full_s, cmd.in_fmt, cmd.in_opcode, cmd.in_imm);
  assign word_s       = encode_word(cmd.in_fmt, cmd.in_opcode, cmd.in_funct3, cmd.in_funct7,
                                    cmd.in_rd, cmd.in_rs1, cmd.in_rs2, cmd.in_imm);

  // Session FSM with registered write port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      count_r    <= '0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= 32'd0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= EC_NONE;
      err_addr_r <= '0;
    end else begin
      we_r <= 1'b0;
      case (state_r)
        S_LOAD: begin
          if (accept_s) begin
            if (code_s == EC_NONE) begin
              we_r    <= 1'b1;
              addr_r  <= wr_addr_s;
              wdata_r <= word_s;
              count_r <= count_r + 1'b1;
              if (cmd.in_last) begin
                state_r <= S_DONE;
                done_r  <= 1'b1;
              end
            end else begin
              // err_addr wraps like the address bus so a full memory reports modulo 2^ADDR_W
              err_r      <= 1'b1;
              err_code_r <= code_s;
              err_addr_r <= wr_addr_s;
              state_r    <= S_ERROR;
            end
          end
        end
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_r    <= S_LOAD;
            count_r    <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= EC_NONE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign imem_we    = we_r;
  assign imem_addr  = addr_r;
  assign imem_wdata = wdata_r;
  assign count      = count_r;
  assign done       = done_r;
  assign err        = err_r;
  assign err_code   = err_code_r;
  assign err_addr   = err_addr_r;

endmodule

// File: doc/instr_assembler.md
# instr_assembler

Streams instruction-field commands (format, opcode, funct, registers, 64-bit signed immediate), packs them into 32-bit RV64 instruction words, and writes them sequentially into instruction memory. It is the encoding counterpart of the immediate decode in the processor's decode stage. Any word it writes decodes back to the same 64-bit immediate. It sits between the program-load path (testbench or boot source) and the instruction-memory write port.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after `start`; capacity DEPTH = 2^ADDR_W − BASE_ADDR

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a load session; honoured only in IDLE, DONE, ERROR
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid && in_ready
- in_fmt  in  2  0=R, 1=I, 2=S, 3=B
- in_opcode  in  7  opcode field
- in_funct3  in  3  funct3 field
- in_funct7  in  7  funct7 field (R only)
- in_rd / in_rs1 / in_rs2  in  5 each  register fields
- in_imm  in  64  signed immediate (I/S/B)
- in_last  in  1  final command of the session
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written this session
- done  out  1  high in DONE
- err  out  1  high in ERROR
- err_code  out  3  0 none, 1 imm range, 2 B misaligned, 3 fmt/opcode mismatch, 4 memory full
- err_addr  out  ADDR_W  address at which the failing command would have been written

## Operation
- FSM states:
  - IDLE: start → LOAD.
  - LOAD: accepting commands.
  - DONE: start → LOAD.
  - ERROR: start → LOAD.
- Entering LOAD clears count, err, err_code and done.
- in_ready = (state == LOAD). No buffering is needed beyond the output register.
- Encoding:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- Checks on the accepted command, in priority order:
  1. full: count == DEPTH → code 4.
  2. fmt/opcode mismatch → code 3. S requires opcode 0100011; B requires 1100011; I and R must not use either of those opcodes.
  3. I/S immediate: in_imm[63:11] must be all-equal (range −2048..2047), else code 1.
  4. B immediate: in_imm[63:12] must be all-equal, else code 1; in_imm[0] must be 0, else code 2. Range failure (code 1) takes precedence over misalignment (code 2).
  5. R: immediate is ignored.
- Valid command: write the word at BASE_ADDR + count, then count++. If in_last is set, go to DONE.
- Failing command: no write, count unchanged, err_addr = BASE_ADDR + count, go to ERROR. in_last is ignored.
- Addresses never wrap; overflow is reported only through code 4.
- start while in LOAD is ignored. Commands presented outside LOAD are not accepted.

## Timing
- Reset values: state IDLE; imem_we, imem_addr, imem_wdata, count, done, err, err_code, err_addr all 0; in_ready 0.
- start sampled in cycle N → in_ready = 1 in cycle N+1.
- Command accepted in cycle N → imem_we = 1 in cycle N+1, with imem_addr and imem_wdata registered. count increments in N+1.
- Throughput is one word per cycle with back-to-back accepts.
- in_last accepted in cycle N → the final write, done = 1 and in_ready = 0 all occur in cycle N+1.
- Error detected at accept in cycle N → err = 1, err_code and err_addr valid, imem_we = 0 and in_ready = 0, all in cycle N+1.
- imem_we is low in every cycle that does not follow a valid accept. imem_addr and imem_wdata hold their last values.
- rst asserted mid-session → all outputs return to reset values immediately. Words already written are not undone, and the pending write is dropped.

## Test plan
- ADDI x1,x0,−1 (fmt I, opcode 0010011, f3 000, rd 1, rs1 0, imm 0xFFFF_FFFF_FFFF_FFFF) after start → cycle after accept: we=1, addr=0, wdata=0xFFF00093, count=1.
- SD x2,8(x3) (fmt S, opcode 0100011, f3 011, rs1 3, rs2 2, imm 8) then BEQ x1,x2,−4 (fmt B, opcode 1100011, f3 000, in_last=1), back-to-back → wdata 0x0021B423 at addr 0, then 0xFE208EE3 at addr 1; done=1 on the second write cycle; the decoded immediates round-trip to 8 and −4.
- fmt I with imm 2048 → no write, err=1, err_code=1, err_addr=0, in_ready=0. Then start → LOAD with err cleared. fmt B with imm 5 → err_code=2. fmt S with opcode 0000011 → err_code=3.
- ADDR_W=2, BASE_ADDR=1: three valid commands → writes at addr 1, 2, 3. Fourth command → err_code=4, err_addr=0, no write.
- rst pulsed while the cycle after an accept is pending → imem_we stays 0, count=0, state IDLE. A subsequent start begins at BASE_ADDR.
- Random legal commands, valid toggled randomly → every written word decodes to the commanded fields and immediate; addresses are contiguous; no we occurs without a preceding accept.
